// File: rtl/hex_display_mux_if.sv
// Display-side bundle for hex_display_mux: frame data and controls in, anode/segment pins out.
// master drives the data and controls; slave is the display driver itself.
interface hex_display_mux_if #(
  parameter int DIGITS      = 4,
  parameter int BRIGHT_BITS = 3
);
  logic [4*DIGITS-1:0]    data;
  logic [DIGITS-1:0]      dp;
  logic                   blank_lz;
  logic [BRIGHT_BITS-1:0] brightness;
  logic [DIGITS-1:0]      anodes;
  logic [7:0]             seg;
  logic                   frame_done;

  modport master (
    output data, dp, blank_lz, brightness,
    input  anodes, seg, frame_done
  );

  modport slave (
    input  data, dp, blank_lz, brightness,
    output anodes, seg, frame_done
  );
endinterface

// File: rtl/hex_display_mux.sv
// Multiplexed seven-segment hex driver: prescaled digit scan, per-frame snapshot,
// leading-zero blanking, decimal points, PWM brightness and selectable pin polarity.
module hex_display_mux #(
  parameter int DIGITS      = 4,
  parameter int DIV_BITS    = 12,
  parameter int BRIGHT_BITS = 3,
  parameter bit ANODE_LOW   = 1'b1,
  parameter bit SEG_LOW     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  hex_display_mux_if.slave  bus
);

  localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODE_OFF = {DIGITS{ANODE_LOW}};
  localparam logic [7:0]        SEG_OFF   = {8{SEG_LOW}};

  logic [DIV_BITS-1:0] pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                blz_q, blz_d;
  logic [DIGITS-1:0]   anodes_q, anodes_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_q, frame_d;

  logic                 preWrap;
  logic                 frameWrap;
  logic [3:0]           curNib;
  logic                 curDp;
  logic                 curBlank;
  logic                 zeroAbove;
  logic [DIGITS-1:0]    oneHot;
  logic [BRIGHT_BITS:0] pwmLevel;
  logic [BRIGHT_BITS:0] pwmThresh;
  logic                 on;

  function automatic logic [6:0] hexGlyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Scan timing: the prescaler wrap steps the digit, the last digit's wrap closes the frame.
  always_comb begin
    preWrap   = &pre_q;
    frameWrap = preWrap && (idx_q == LAST_IDX);
    pre_d     = pre_q + 1'b1;
    idx_d     = idx_q;
    if (preWrap) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    data_d  = data_q;
    dp_d    = dp_q;
    blz_d   = blz_q;
    frame_d = frameWrap;
    if (frameWrap) begin
      data_d = bus.data;
      dp_d   = bus.dp;
      blz_d  = bus.blank_lz;
    end
  end

  // Walk from the most significant digit down so zeroAbove covers nibbles DIGITS-1..i.
  always_comb begin
    curNib    = 4'h0;
    curDp     = 1'b0;
    curBlank  = 1'b0;
    zeroAbove = 1'b1;
    oneHot    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeroAbove = zeroAbove & (data_q[4*i +: 4] == 4'h0);
      oneHot[i] = (idx_q == IDX_W'(i));
      if (idx_q == IDX_W'(i)) begin
        curNib   = data_q[4*i +: 4];
        curDp    = dp_q[i];
        curBlank = blz_q && zeroAbove && (i != 0);
      end
    end
  end

  // PWM compares the prescaler's top bits against brightness+1 one bit wider, so all-ones is 100%.
  always_comb begin
    pwmLevel  = {1'b0, pre_q[DIV_BITS-1 -: BRIGHT_BITS]};
    pwmThresh = {1'b0, bus.brightness} + 1'b1;
    on        = (pwmLevel < pwmThresh);
    anodes_d  = ANODE_OFF;
    seg_d     = SEG_OFF;
    if (on) begin
      anodes_d = oneHot ^ ANODE_OFF;
      seg_d    = {curDp, curBlank ? 7'h00 : hexGlyph(curNib)} ^ SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      dp_q     <= '0;
      blz_q    <= 1'b0;
      anodes_q <= ANODE_OFF;
      seg_q    <= SEG_OFF;
      frame_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      dp_q     <= dp_d;
      blz_q    <= blz_d;
      anodes_q <= anodes_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.anodes     = anodes_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux (4 digits, 16-cycle slots, 2-bit brightness, active-low pins).
module tb_hex_display_mux;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blz;
    logic [1:0]  bright;
    logic [31:0] segs;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs [7];

  hex_display_mux_if #(.DIGITS(4), .BRIGHT_BITS(2)) bus ();

  hex_display_mux #(
    .DIGITS(4), .DIV_BITS(4), .BRIGHT_BITS(2), .ANODE_LOW(1'b1), .SEG_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.data       = v.data;
    bus.dp         = v.dp;
    bus.blank_lz   = v.blz;
    bus.brightness = v.bright;
  endtask

  task automatic waitFrame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 200);
    checks++;
    if (!bus.frame_done) begin
      failures++;
      $display("[TB] FAIL %s frame_done timeout actual=0 expected=1", tag);
    end
  endtask

  // Checks the 64 samples following a frame_done sample; sample k shows scan count k-1.
  task automatic checkFrame(input string tag, input logic [31:0] segs, input logic [1:0] br,
                            input bit doChange, input vec_t nextV);
    int       slot;
    int       p;
    bit       on;
    logic [3:0] expA;
    logic [7:0] expS;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      slot = (k - 1) / 16;
      p    = (k - 1) % 16;
      on   = ((p >> 2) < (int'(br) + 1));
      expA = on ? ~(4'b0001 << slot) : 4'hF;
      expS = on ? segs[8*slot +: 8] : 8'hFF;
      checkOutput($sformatf("%s anodes k=%0d", tag, k), {4'h0, bus.anodes}, {4'h0, expA});
      checkOutput($sformatf("%s seg k=%0d", tag, k), bus.seg, expS);
      checkOutput($sformatf("%s frame_done k=%0d", tag, k), {7'h0, bus.frame_done}, {7'h0, (k == 64)});
      if (doChange && k == 20) applyStimulus(nextV);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{data:16'h1234, dp:4'h0, blz:1'b0, bright:2'd3, segs:32'hF9A4B099};
    vecs[1] = '{data:16'h00A5, dp:4'h0, blz:1'b1, bright:2'd3, segs:32'hFFFF8892};
    vecs[2] = '{data:16'h0000, dp:4'h4, blz:1'b1, bright:2'd3, segs:32'hFF7FFFC0};
    vecs[3] = '{data:16'h0F3C, dp:4'h9, blz:1'b1, bright:2'd1, segs:32'h7F8EB046};
    vecs[4] = '{data:16'h1009, dp:4'h0, blz:1'b1, bright:2'd0, segs:32'hF9C0C090};
    vecs[5] = '{data:16'h0080, dp:4'h0, blz:1'b1, bright:2'd2, segs:32'hFFFF80C0};
    vecs[6] = '{data:16'hBD67, dp:4'h2, blz:1'b0, bright:2'd3, segs:32'h83A102F8};

    // Reset held: outputs inactive regardless of data.
    rst_n = 1'b0;
    applyStimulus(vecs[0]);
    repeat (3) @(negedge clk);
    checkOutput("reset anodes", {4'h0, bus.anodes}, 8'h0F);
    checkOutput("reset seg", bus.seg, 8'hFF);
    checkOutput("reset frame_done", {7'h0, bus.frame_done}, 8'h00);
    rst_n = 1'b1;

    // Frame 0 shows the all-zero snapshot, then the data present at its end.
    checkFrame("frame0", 32'hC0C0C0C0, 2'd3, 1'b0, vecs[0]);
    checkFrame("frame1", vecs[0].segs, 2'd3, 1'b0, vecs[0]);

    for (int i = 1; i < 7; i++) begin
      applyStimulus(vecs[i]);
      waitFrame($sformatf("vec%0d", i));
      checkFrame($sformatf("vec%0d", i), vecs[i].segs, vecs[i].bright, 1'b0, vecs[i]);
    end

    // Mid-frame data change is held off until the next snapshot.
    checkFrame("midchange", vecs[6].segs, vecs[6].bright, 1'b1, vecs[0]);
    checkFrame("afterchange", vecs[0].segs, vecs[0].bright, 1'b0, vecs[0]);

    // Asynchronous reset in the middle of digit 2's slot.
    repeat (39) @(negedge clk);
    @(negedge clk);
    checkOutput("premidreset anodes", {4'h0, bus.anodes}, 8'h0B);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset anodes", {4'h0, bus.anodes}, 8'h0F);
    checkOutput("midreset seg", bus.seg, 8'hFF);
    checkOutput("midreset frame_done", {7'h0, bus.frame_done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    checkFrame("postreset0", 32'hC0C0C0C0, 2'd3, 1'b0, vecs[0]);
    checkFrame("postreset1", vecs[0].segs, 2'd3, 1'b0, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
